// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: iterative shift-add MULT/MULTU sequencer with HI/LO and stall.
// Optional early termination when the multiplier runs out of set bits: MULT_EARLY_OUT_EN.
module mult_seq_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       control,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [3:0] OP_MULT  = 4'b1000;
   localparam logic [3:0] OP_MULTU = 4'b1001;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FINISH
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic               w_accept;
   logic               w_write;
   logic               w_signed;
   logic               w_last;
   logic [WIDTH-1:0]   w_op_a;
   logic [WIDTH-1:0]   w_op_b;
   logic [WIDTH-1:0]   w_mplier_sh;
   logic [2*WIDTH-1:0] w_prod;

   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_neg;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   // Operand conditioning: magnitudes for signed, raw for unsigned.
   always_comb begin
      w_signed    = (control == OP_MULT);
      w_op_a      = (w_signed && a[WIDTH-1]) ? -a : a;
      w_op_b      = (w_signed && b[WIDTH-1]) ? -b : b;
      w_mplier_sh = r_mplier >> 1;
      w_prod      = r_neg ? -r_acc : r_acc;
`ifdef MULT_EARLY_OUT_EN
      w_last      = (r_cnt == CNT_W'(WIDTH-1)) || (w_mplier_sh == '0);
`else
      w_last      = (r_cnt == CNT_W'(WIDTH-1));
`endif
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state and control strobes; flush always wins.
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_write  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (!flush && start &&
                (control == OP_MULT || control == OP_MULTU)) begin
               w_accept = 1'b1;
`ifdef MULT_EARLY_OUT_EN
               w_next   = (w_op_b == '0) ? S_FINISH : S_RUN;
`else
               w_next   = S_RUN;
`endif
            end
         end
         S_RUN: begin
            if (flush)       w_next = S_IDLE;
            else if (w_last) w_next = S_FINISH;
         end
         S_FINISH: begin
            w_next  = S_IDLE;
            w_write = !flush;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Shift-add datapath and HI/LO result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_neg    <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         if (w_accept) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_op_a};
            r_mplier <= w_op_b;
            r_neg    <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_acc    <= '0;
            r_cnt    <= '0;
         end else if (r_state == S_RUN) begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= w_mplier_sh;
            r_cnt    <= r_cnt + CNT_W'(1);
         end
         if (w_write) begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
         end
      end
   end

   assign busy  = (r_state != S_IDLE);
   assign stall = busy;
   assign done  = w_write;
   assign hi    = r_hi;
   assign lo    = r_lo;

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Multi-cycle sequencer for the MULT/MULTU operations selected by the 4-bit ALU control code (4'b1000 signed, 4'b1001 unsigned).
- Runs an iterative shift-add multiply, one multiplier bit per cycle, and writes the 64-bit result to HI/LO.
- Drives `stall` so the pipeline holds while the product is being formed.
- Sits beside the ALU in the EX stage and is fed by the same control decode.

Parameters:
- WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to begin a multiply this cycle
- control  input  4  ALU control code; only 4'b1000 and 4'b1001 are accepted
- a  input  WIDTH  multiplicand (rs)
- b  input  WIDTH  multiplier (rt)
- flush  input  1  abort any operation in progress
- busy  output  1  high when the state is not IDLE
- stall  output  1  pipeline hold; equals busy
- done  output  1  one-cycle pulse when HI/LO have just been updated
- hi  output  WIDTH  upper half of the product
- lo  output  WIDTH  lower half of the product

Interface: one clock, clk. Reset rst_n is asynchronous and active-low.

Behaviour:
- Reset (asserted at any time, including mid-operation):
  - state=IDLE; busy=stall=done=0; hi=lo=0; internal accumulator, counter and sign flag cleared.
- States: IDLE, RUN, FINISH.
- IDLE:
  - Accept when start=1 and control is 4'b1000 or 4'b1001.
  - Any other control value, or start=0, leaves the state in IDLE and all outputs unchanged.
- On accept (cycle T):
  - Latch operands: mcand=|a| and mplier=|b| if signed, otherwise raw a and b.
  - Set neg=a[WIDTH-1]^b[WIDTH-1] when signed, else neg=0.
  - Clear the 2*WIDTH accumulator and the counter; go to RUN.
- Absolute-value rule: |x| is the two's complement taken as an unsigned WIDTH-bit value, so 0x80000000 maps to 0x80000000 unsigned.
- RUN, each cycle:
  - If mplier[0]=1, add mcand (zero-extended to 2*WIDTH) to the accumulator.
  - Shift mcand left by 1 within 2*WIDTH; shift mplier right by 1; counter++.
  - After WIDTH iterations (counter==WIDTH-1 on the current cycle), go to FINISH.
- FINISH (a single cycle):
  - {hi,lo} <= neg ? -acc : acc, with the negation done modulo 2^(2*WIDTH).
  - done=1 for this cycle only; next state IDLE.
- Latency:
  - Accept at T; RUN occupies T+1..T+WIDTH; FINISH at T+WIDTH+1.
  - New hi/lo are visible from T+WIDTH+2.
  - busy=1 from T+1 through T+WIDTH+1 inclusive.
- start while busy: ignored; no queuing.
- hi/lo hold their value between operations and change only on a FINISH cycle.
- flush:
  - In RUN or FINISH, the next state is IDLE; hi/lo stay unchanged and done stays 0.
  - flush overrides the FINISH write in the same cycle.
  - flush in IDLE blocks any start in that cycle.
- start and flush together in IDLE: flush wins; nothing is accepted.

Optional Feature:
- Macro: MULT_EARLY_OUT_EN.
- When defined:
  - In RUN, if the shifted mplier value about to be registered is zero, go to FINISH next cycle regardless of the counter.
  - Accept with b==0: go directly to FINISH at T+1 with acc=0.
  - Results are identical to the fixed-latency mode; only latency shrinks, to (index of the highest set bit of |b|) + 1 RUN cycles.
- When undefined: fixed latency of WIDTH RUN cycles as above.

Test Plan:
- Unsigned small: control=1001, a=3, b=5, start pulse → done pulse exactly 33 cycles after accept; hi=0x00000000, lo=0x0000000F.
- Signed negative: control=1000, a=0xFFFFFFFE (-2), b=3 → hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high for 33 cycles.
- Unsigned max: control=1001, a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- Signed corner: control=1000, a=b=0x80000000 → hi=0x40000000, lo=0x00000000.
- Rejection and control:
  - start with control=0010 → busy stays 0 and hi/lo unchanged.
  - start asserted while busy → ignored; the first result completes unchanged.
- Abort:
  - flush at RUN cycle 10 → busy=0 next cycle, no done pulse, hi/lo keep their prior result.
  - rst_n low mid-RUN → outputs cleared immediately (asynchronous); with MULT_EARLY_OUT_EN, 3*5 gives done 4 cycles after accept.
